seg_time_monitor: RTL
=====================

// Module: seg_time_monitor
// PURPOSE
//  Receive-side checker for the sec/min counter's display outputs. It decodes the two
//  7-segment digit buses back to BCD and tracks the count value. It flags illegal glyphs,
//  out-of-sequence steps and wrong carry. It sits beside the counter on board or in benches
//  and drives status LEDs and an error counter.
// PARAMETERS
//  MODULUS     60  count wraps MODULUS-1 -> 0 (2..99)
//  ACTIVE_LOW  1   1: a lit segment is 0 on seg*; 0: a lit segment is 1
// PORTS
//  clk        in   1  system clock
//  glob_rst   in   1  synchronous, active-high reset
//  ce         in   1  count enable seen by the counter (same-cycle copy)
//  carry_in   in   1  counter carry_out
//  src_rst    in   1  source counter is being reset (active-high); expect 00 next
//  seg1       in   7  tens digit segments {g,f,e,d,c,b,a}
//  seg0       in   7  units digit segments {g,f,e,d,c,b,a}
//  bcd1       out  4  decoded tens (registered)
//  bcd0       out  4  decoded units (registered)
//  locked     out  1  state==TRACK
//  glyph_err  out  1  1-cycle pulse: a digit pattern is not 0-9
//  seq_err    out  1  1-cycle pulse: value change is not +1 mod MODULUS
//  carry_err  out  1  1-cycle pulse: carry_in disagrees with expected
//  wrap       out  1  1-cycle pulse: legal MODULUS-1 -> 0 step seen
//  err_cnt    out  8  saturating count of all error pulses (max 255)
// BEHAVIOUR
//  Glyphs (active-high, {g..a}):
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   Input is inverted first when ACTIVE_LOW=1. Any other pattern is illegal.
//  Stage 1 (sample at cycle n -> valid at n+1): bcd1/bcd0 <= decoded value; g_ok <= both legal.
//   An illegal digit holds its previous bcd value. An illegal value >= MODULUS also sets g_ok=0.
//  Stage 2 (flags at n+2): compare stage-1 value V with held value P.
//  FSM states:
//   SYNC : on g_ok -> P<=V, TRACK.
//   TRACK: V==P -> no action. V==(P+1)%MODULUS -> P<=V; wrap=1 if P==MODULUS-1.
//          Any other change -> seq_err, P<=V (resync, stay TRACK).
//          !g_ok -> glyph_err, stay TRACK, P unchanged.
//  src_rst=1 in any cycle: the next changes to 00 are legal. State -> SYNC, no seq_err.
//  carry check (TRACK only): on a cycle with ce=1, expected carry = (P==MODULUS-1).
//   carry_in != expected -> carry_err two cycles later (same pipeline as other flags).
//  Simultaneous errors: every flag pulses independently. err_cnt adds the number of
//   flags set that cycle (0-3) and saturates at 255.
//  glob_rst: state=SYNC; bcd1=bcd0=0; P=0; all pulses=0; err_cnt=0; locked=0.
//   A mid-operation reset discards the pipeline: no flag fires for pre-reset samples.
//  Width rules: P+1 is computed in 7 bits and compared as a binary value (tens*10+units).
// TESTING
//  1. Reset, feed 00..59..00 legal (ACTIVE_LOW), ce each 10 cycles
//     -> locked by cycle 3, wrap once at 59->00, err_cnt=0.
//  2. In TRACK, hold 23 then jump to 25 -> seq_err single pulse 2 cycles later,
//     bcd=25, err_cnt=1, next 26 accepted.
//  3. seg0=7'h00 (inverted 7F? no: raw all-lit) vs illegal 7'h55
//     -> glyph_err pulses, bcd0 holds, locked stays 1.
//  4. Assert src_rst at value 41, then feed 00 -> no seq_err, relock, err_cnt unchanged.
//  5. ce=1 at value 59 with carry_in=0, and at 30 with carry_in=1 -> two carry_err pulses.
//  6. Force 300 errors -> err_cnt saturates at 255. glob_rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/seg_time_monitor.sv
// rtl/seg_time_monitor.sv - decodes a two-digit 7-segment display and checks it counts legally
// Stage 1 decodes glyphs to BCD; stage 2 tracks the held value and pulses error/wrap flags.
module seg_time_monitor #(
  parameter int MODULUS    = 60,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       glob_rst,
  input  logic       ce,
  input  logic       carry_in,
  input  logic       src_rst,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       locked,
  output logic       glyph_err,
  output logic       seq_err,
  output logic       carry_err,
  output logic       wrap,
  output logic [7:0] err_cnt
);

  typedef enum logic {SYNC, TRACK} state_t;

  localparam logic [6:0] LAST = 7'(MODULUS - 1);

  // Returns {legal, digit}; digit is zero when the pattern is not a 0-9 glyph.
  function automatic logic [4:0] decode(input logic [6:0] raw);
    logic [6:0] s;
    s = ACTIVE_LOW ? ~raw : raw;
    case (s)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h6F:   decode = {1'b1, 4'd9};
      default: decode = 5'd0;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [3:0] bcd1_q, bcd1_d, bcd0_q, bcd0_d;
  logic       g_ok_q, g_ok_d;
  logic       ce1_q, ce1_d, carry1_q, carry1_d, src1_q, src1_d;
  logic [6:0] p_q, p_d;
  logic       glyph_q, glyph_d, seq_q, seq_d, carry_q, carry_d, wrap_q, wrap_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic [4:0] dec1, dec0;
  logic [6:0] val_d, val_q, p_inc;
  logic [1:0] err_sum;
  logic [8:0] err_tot;

  always_comb begin
    dec1     = decode(seg1);
    dec0     = decode(seg0);
    bcd1_d   = dec1[4] ? dec1[3:0] : bcd1_q;
    bcd0_d   = dec0[4] ? dec0[3:0] : bcd0_q;
    val_d    = 7'(bcd1_d) * 7'd10 + 7'(bcd0_d);
    g_ok_d   = dec1[4] & dec0[4] & (val_d <= LAST);
    ce1_d    = ce;
    carry1_d = carry_in;
    src1_d   = src_rst;
  end

  always_comb begin
    val_q   = 7'(bcd1_q) * 7'd10 + 7'(bcd0_q);
    p_inc   = (p_q == LAST) ? 7'd0 : p_q + 7'd1;
    state_d = state_q;
    p_d     = p_q;
    glyph_d = 1'b0;
    seq_d   = 1'b0;
    carry_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      SYNC: begin
        if (!src1_q && g_ok_q) begin
          p_d     = val_q;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (src1_q) begin
          state_d = SYNC;
        end else begin
          if (!g_ok_q) begin
            glyph_d = 1'b1;
          end else if (val_q == p_inc) begin
            p_d    = val_q;
            wrap_d = (p_q == LAST);
          end else if (val_q != p_q) begin
            seq_d = 1'b1;
            p_d   = val_q;
          end
          // Carry is judged against the value the counter showed when ce was high.
          carry_d = ce1_q && (carry1_q != (p_d == LAST));
        end
      end
      default: state_d = SYNC;
    endcase
    err_sum   = {1'b0, glyph_d} + {1'b0, seq_d} + {1'b0, carry_d};
    err_tot   = {1'b0, err_cnt_q} + {7'd0, err_sum};
    err_cnt_d = err_tot[8] ? 8'hFF : err_tot[7:0];
  end

  always_ff @(posedge clk) begin
    if (glob_rst) begin
      state_q   <= SYNC;
      bcd1_q    <= 4'd0;
      bcd0_q    <= 4'd0;
      g_ok_q    <= 1'b0;
      ce1_q     <= 1'b0;
      carry1_q  <= 1'b0;
      src1_q    <= 1'b0;
      p_q       <= 7'd0;
      glyph_q   <= 1'b0;
      seq_q     <= 1'b0;
      carry_q   <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bcd1_q    <= bcd1_d;
      bcd0_q    <= bcd0_d;
      g_ok_q    <= g_ok_d;
      ce1_q     <= ce1_d;
      carry1_q  <= carry1_d;
      src1_q    <= src1_d;
      p_q       <= p_d;
      glyph_q   <= glyph_d;
      seq_q     <= seq_d;
      carry_q   <= carry_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bcd1      = bcd1_q;
  assign bcd0      = bcd0_q;
  assign locked    = (state_q == TRACK);
  assign glyph_err = glyph_q;
  assign seq_err   = seq_q;
  assign carry_err = carry_q;
  assign wrap      = wrap_q;
  assign err_cnt   = err_cnt_q;

endmodule
